// File: rtl/arb_rr.sv
// Registered round-robin arbiter with locked grants and a valid/ready output handshake.
// Optional grant release on a withdrawn request is enabled by defining ARB_RR_DROP_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant outstanding, outputs zero, arbitrate on any request
// ST_GRANT | one-hot grant held until vld & rdy (or a drop, if enabled)
module arb_rr #(
    parameter int WIDTH = 9,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld,
    input  logic             rdy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [WIDTH-1:0] ONE_HOT_0 = WIDTH'(1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;

    logic             xfer;
    logic             drop;
    logic [IDX_W-1:0] ptr_inc;
    logic [WIDTH-1:0] sel_req;
    logic [IDX_W-1:0] sel_ptr;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;

    always_comb begin
        xfer    = vld_q & rdy;
        ptr_inc = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
`ifdef ARB_RR_DROP_EN
        drop    = (state_q == ST_GRANT) & ~rdy & ~|(req & gnt_q);
`else
        drop    = 1'b0;
`endif
        // The granted bit is masked so it cannot win twice in a row.
        sel_req = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;
        sel_ptr = xfer ? ptr_inc : ptr_q;
    end

    // Lowest set bit overall, then overridden by the lowest set bit at or above the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (sel_req[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (sel_req[i] && (i >= int'(sel_ptr))) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = ONE_HOT_0 << sel_idx;
                    idx_d   = sel_idx;
                end else begin
                    gnt_d = '0;
                    idx_d = '0;
                end
            end
            ST_GRANT: begin
                if (xfer || drop) begin
                    ptr_d = sel_ptr;
                    if (sel_found) begin
                        gnt_d = ONE_HOT_0 << sel_idx;
                        idx_d = sel_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        vld_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt = gnt_q;
    assign idx = idx_q;
    assign vld = vld_q;

endmodule

// File: tb/tb_arb_rr.sv
// Directed bench for arb_rr: reset, rotation, backpressure, wrap, drop and async reset.
module tb_arb_rr;

    localparam int WIDTH = 9;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] gnt;
    logic [IDX_W-1:0] idx;
    logic             vld;
    logic             rdy;

    int total = 0;
    int bad   = 0;

    arb_rr #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .idx   (idx),
        .vld   (vld),
        .rdy   (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] r, input logic rd);
        rst_n = 1'b0;
        req   = r;
        rdy   = rd;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(9'h1FF, 1'b1);
        rst_n = 1'b0;
        tick();
        total++; if (gnt !== 9'h000) begin bad++; $display("FAIL reset_gnt got=%h want=%h", gnt, 9'h000); end
        total++; if (idx !== 4'd0)   begin bad++; $display("FAIL reset_idx got=%0d want=0", idx); end
        total++; if (vld !== 1'b0)   begin bad++; $display("FAIL reset_vld got=%b want=0", vld); end
        rst_n = 1'b1;
        tick();
        total++; if (gnt !== 9'h001) begin bad++; $display("FAIL first_gnt got=%h want=%h", gnt, 9'h001); end
        total++; if (idx !== 4'd0)   begin bad++; $display("FAIL first_idx got=%0d want=0", idx); end
        total++; if (vld !== 1'b1)   begin bad++; $display("FAIL first_vld got=%b want=1", vld); end
    endtask

    // Continues from test_reset: grant on 0, req all ones, rdy high.
    task automatic test_full_rr();
        logic [WIDTH-1:0] exp_gnt;
        int k;
        for (int i = 0; i < 10; i++) begin
            tick();
            k = (i + 1) % WIDTH;
            exp_gnt = '0;
            exp_gnt[k] = 1'b1;
            total++; if (idx !== IDX_W'(k)) begin bad++; $display("FAIL rr_idx step=%0d got=%0d want=%0d", i, idx, k); end
            total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt step=%0d got=%h want=%h", i, gnt, exp_gnt); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(9'h014, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (gnt !== 9'h004) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, gnt, 9'h004); end
        end
        req = 9'h0FC;
        tick();
        total++; if (gnt !== 9'h004) begin bad++; $display("FAIL bp_req_change got=%h want=%h", gnt, 9'h004); end
        req = 9'h014;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        total++; if (gnt !== 9'h010) begin bad++; $display("FAIL bp_next_gnt got=%h want=%h", gnt, 9'h010); end
        total++; if (idx !== 4'd4)   begin bad++; $display("FAIL bp_next_idx got=%0d want=4", idx); end
        tick();
        total++; if (gnt !== 9'h010) begin bad++; $display("FAIL bp_hold2 got=%h want=%h", gnt, 9'h010); end
    endtask

    task automatic test_sparse_wrap();
        do_reset(9'h040, 1'b1);
        tick();
        total++; if (gnt !== 9'h040) begin bad++; $display("FAIL wrap_setup got=%h want=%h", gnt, 9'h040); end
        req = 9'h003;
        tick();
        total++; if (gnt !== 9'h001) begin bad++; $display("FAIL wrap_gnt got=%h want=%h", gnt, 9'h001); end
        total++; if (idx !== 4'd0)   begin bad++; $display("FAIL wrap_idx got=%0d want=0", idx); end
        tick();
        total++; if (gnt !== 9'h002) begin bad++; $display("FAIL wrap_next got=%h want=%h", gnt, 9'h002); end
    endtask

    task automatic test_single_alternate();
        logic [WIDTH-1:0] exp_gnt;
        do_reset(9'h001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_gnt = (i % 2 == 0) ? 9'h001 : 9'h000;
            total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL alt_gnt cyc=%0d got=%h want=%h", i, gnt, exp_gnt); end
            total++; if (vld !== |exp_gnt) begin bad++; $display("FAIL alt_vld cyc=%0d got=%b want=%b", i, vld, |exp_gnt); end
        end
    endtask

    task automatic test_drop();
        do_reset(9'h028, 1'b0);
        tick();
        total++; if (gnt !== 9'h008) begin bad++; $display("FAIL drop_setup got=%h want=%h", gnt, 9'h008); end
        req = 9'h020;
        tick();
`ifdef ARB_RR_DROP_EN
        total++; if (gnt !== 9'h020) begin bad++; $display("FAIL drop_gnt got=%h want=%h", gnt, 9'h020); end
        total++; if (idx !== 4'd5)   begin bad++; $display("FAIL drop_idx got=%0d want=5", idx); end
        do_reset(9'h028, 1'b0);
        tick();
        req = 9'h022;
        tick();
        total++; if (gnt !== 9'h002) begin bad++; $display("FAIL drop_ptr got=%h want=%h", gnt, 9'h002); end
`else
        total++; if (gnt !== 9'h008) begin bad++; $display("FAIL nodrop_hold got=%h want=%h", gnt, 9'h008); end
        tick();
        total++; if (gnt !== 9'h008) begin bad++; $display("FAIL nodrop_hold2 got=%h want=%h", gnt, 9'h008); end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        total++; if (gnt !== 9'h020) begin bad++; $display("FAIL nodrop_after got=%h want=%h", gnt, 9'h020); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset(9'h100, 1'b0);
        tick();
        total++; if (gnt !== 9'h100) begin bad++; $display("FAIL arst_setup got=%h want=%h", gnt, 9'h100); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (gnt !== 9'h000) begin bad++; $display("FAIL arst_gnt got=%h want=%h", gnt, 9'h000); end
        total++; if (vld !== 1'b0)   begin bad++; $display("FAIL arst_vld got=%b want=0", vld); end
        #1;
        rst_n = 1'b1;
        tick();
        total++; if (gnt !== 9'h100) begin bad++; $display("FAIL arst_regrant got=%h want=%h", gnt, 9'h100); end
        total++; if (idx !== 4'd8)   begin bad++; $display("FAIL arst_idx got=%0d want=8", idx); end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        rdy   = 1'b0;
        test_reset();
        test_full_rr();
        test_backpressure();
        test_sparse_wrap();
        test_single_alternate();
        test_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
